// File: rtl/ip_daec_rd_resp_buffer_if.sv
// Stream bundle between the DAEC decoder, the read-response buffer and its consumer.
// The slave modport is the buffer's view. The master modport is the view of the environment driving the buffer.
interface ip_daec_rd_resp_buffer_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        in_err_loc;
    logic              in_due;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_poison;

    modport slave (
        input  in_valid, in_data, in_err_loc, in_due, out_ready,
        output in_ready, out_valid, out_data, out_poison
    );

    modport master (
        output in_valid, in_data, in_err_loc, in_due, out_ready,
        input  in_ready, out_valid, out_data, out_poison
    );
endinterface

// File: rtl/ip_daec_rd_resp_buffer.sv
// First-word-fall-through buffer for decoded read responses.
// It tags poisoned entries and keeps saturating CE/DUE telemetry, a last-error log and a sticky DUE irq.
module ip_daec_rd_resp_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ip_daec_rd_resp_buffer_if.slave  bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         ce_cnt,
    output logic [CNT_W-1:0]         due_cnt,
    output logic [3:0]               last_err_loc,
    output logic                     last_err_vld,
    output logic                     irq_due,
    input  logic                     clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Each entry is {data, poison}; the poison bit sits at bit 0.
    logic [DATA_W:0]     mem_q [DEPTH];
    logic [DATA_W:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [CNT_W-1:0]    ce_cnt_q, ce_cnt_d;
    logic [CNT_W-1:0]    due_cnt_q, due_cnt_d;
    logic [3:0]          last_err_loc_q, last_err_loc_d;
    logic                last_err_vld_q, last_err_vld_d;
    logic                irq_due_q, irq_due_d;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                cls_ce;
    logic                cls_due;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;

    // Locations 10..14 cannot occur in a 10-symbol codeword, so they are treated as uncorrectable.
    assign cls_due = bus.in_due || ((bus.in_err_loc >= 4'd10) && (bus.in_err_loc <= 4'd14));
    assign cls_ce  = !bus.in_due && (bus.in_err_loc <= 4'd9);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_data, cls_due};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // clr wins over any event accepted in the same cycle.
    always_comb begin
        ce_cnt_d       = ce_cnt_q;
        due_cnt_d      = due_cnt_q;
        last_err_loc_d = last_err_loc_q;
        last_err_vld_d = last_err_vld_q;
        irq_due_d      = irq_due_q;
        if (clr) begin
            ce_cnt_d       = '0;
            due_cnt_d      = '0;
            last_err_loc_d = 4'hF;
            last_err_vld_d = 1'b0;
            irq_due_d      = 1'b0;
        end else if (push && cls_due) begin
            if (due_cnt_q != '1) begin
                due_cnt_d = due_cnt_q + CNT_W'(1);
            end
            last_err_loc_d = 4'hE;
            last_err_vld_d = 1'b1;
            irq_due_d      = 1'b1;
        end else if (push && cls_ce) begin
            if (ce_cnt_q != '1) begin
                ce_cnt_d = ce_cnt_q + CNT_W'(1);
            end
            last_err_loc_d = bus.in_err_loc;
            last_err_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            ce_cnt_q       <= '0;
            due_cnt_q      <= '0;
            last_err_loc_q <= 4'hF;
            last_err_vld_q <= 1'b0;
            irq_due_q      <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            ce_cnt_q       <= ce_cnt_d;
            due_cnt_q      <= due_cnt_d;
            last_err_loc_q <= last_err_loc_d;
            last_err_vld_q <= last_err_vld_d;
            irq_due_q      <= irq_due_d;
        end
    end

    // The head is read straight from storage, so it holds while the consumer stalls.
    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_data   = mem_q[rd_ptr_q][DATA_W:1];
    assign bus.out_poison = mem_q[rd_ptr_q][0];

    assign level        = level_q;
    assign ce_cnt       = ce_cnt_q;
    assign due_cnt      = due_cnt_q;
    assign last_err_loc = last_err_loc_q;
    assign last_err_vld = last_err_vld_q;
    assign irq_due      = irq_due_q;
endmodule

// File: tb/tb_ip_daec_rd_resp_buffer.sv
// Directed bench for ip_daec_rd_resp_buffer.
// It uses a 4-bit counter width so that counter saturation is reachable quickly.
module tb_ip_daec_rd_resp_buffer;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [2:0]        level;
    logic [CNT_W-1:0]  ce_cnt;
    logic [CNT_W-1:0]  due_cnt;
    logic [3:0]        last_err_loc;
    logic              last_err_vld;
    logic              irq_due;

    int cnt_cmp;
    int cnt_mis;

    ip_daec_rd_resp_buffer_if #(.DATA_W(DATA_W)) bus ();

    ip_daec_rd_resp_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .level       (level),
        .ce_cnt      (ce_cnt),
        .due_cnt     (due_cnt),
        .last_err_loc(last_err_loc),
        .last_err_vld(last_err_vld),
        .irq_due     (irq_due),
        .clr         (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cnt_cmp++;
        if (got !== exp) begin
            cnt_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] d, input logic [3:0] loc, input logic due);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_err_loc = loc;
        bus.in_due     = due;
        tick();
        bus.in_valid   = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] d, input logic poison);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_poison"}, 64'(bus.out_poison), 64'(poison));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    logic [63:0] exp_q [4];

    initial begin
        cnt_cmp        = 0;
        cnt_mis        = 0;
        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_err_loc = 4'hF;
        bus.in_due     = 1'b0;
        bus.out_ready  = 1'b0;
        #23;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_poison", 64'(bus.out_poison), 64'd0);
        chk("rst_ce_cnt", 64'(ce_cnt), 64'd0);
        chk("rst_due_cnt", 64'(due_cnt), 64'd0);
        chk("rst_last_loc", 64'(last_err_loc), 64'hF);
        chk("rst_last_vld", 64'(last_err_vld), 64'd0);
        chk("rst_irq", 64'(irq_due), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Clean stream: four clean words fill the FIFO, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            push_word(64'(i), 4'hF, 1'b0);
        end
        chk("clean_level_full", 64'(level), 64'd4);
        chk("clean_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            pop_expect($sformatf("clean_pop%0d", i), 64'(i), 1'b0);
        end
        chk("clean_level_empty", 64'(level), 64'd0);
        chk("clean_ce", 64'(ce_cnt), 64'd0);
        chk("clean_due", 64'(due_cnt), 64'd0);

        // CE logging on two different symbols.
        push_word(64'hA, 4'd9, 1'b0);
        chk("ce1_cnt", 64'(ce_cnt), 64'd1);
        chk("ce1_loc", 64'(last_err_loc), 64'd9);
        chk("ce1_vld", 64'(last_err_vld), 64'd1);
        chk("ce1_irq", 64'(irq_due), 64'd0);
        push_word(64'hB, 4'd3, 1'b0);
        chk("ce2_cnt", 64'(ce_cnt), 64'd2);
        chk("ce2_loc", 64'(last_err_loc), 64'd3);
        pop_expect("ce_popA", 64'hA, 1'b0);
        pop_expect("ce_popB", 64'hB, 1'b0);

        // A DUE ignores its location. An illegal location counts as a DUE.
        push_word(64'hC, 4'd5, 1'b1);
        chk("due1_cnt", 64'(due_cnt), 64'd1);
        chk("due1_loc", 64'(last_err_loc), 64'hE);
        chk("due1_irq", 64'(irq_due), 64'd1);
        chk("due1_ce", 64'(ce_cnt), 64'd2);
        pop_expect("due1_pop", 64'hC, 1'b1);
        push_word(64'hD, 4'd12, 1'b0);
        chk("ill_due_cnt", 64'(due_cnt), 64'd2);
        chk("ill_ce_cnt", 64'(ce_cnt), 64'd2);
        chk("ill_loc", 64'(last_err_loc), 64'hE);
        pop_expect("ill_pop", 64'hD, 1'b1);

        // Full boundary: a pop while full must not admit a push in the same cycle.
        exp_q[0] = 64'h11; exp_q[1] = 64'h12; exp_q[2] = 64'h13; exp_q[3] = 64'h20;
        push_word(64'h10, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_word(exp_q[i], 4'hF, 1'b0);
        end
        bus.in_valid   = 1'b1;
        bus.in_data    = 64'h20;
        bus.in_err_loc = 4'hF;
        bus.in_due     = 1'b0;
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready  = 1'b1;
        tick();
        bus.out_ready  = 1'b0;
        chk("full_pop_level", 64'(level), 64'd3);
        chk("full_pop_head", bus.out_data, 64'h11);
        chk("full_ready_again", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid   = 1'b0;
        chk("full_refill_level", 64'(level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            pop_expect($sformatf("full_pop%0d", i), exp_q[i], 1'b0);
        end

        // Clear, then drive 20 CE accepts through a flowing FIFO to reach saturation.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ce", 64'(ce_cnt), 64'd0);
        chk("clr_due", 64'(due_cnt), 64'd0);
        chk("clr_irq", 64'(irq_due), 64'd0);
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_err_loc = 4'd1;
        bus.in_due     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 64'(100 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("sat_ce", 64'(ce_cnt), 64'd15);
        chk("sat_loc", 64'(last_err_loc), 64'd1);
        tick();
        bus.out_ready = 1'b0;
        chk("sat_drained", 64'(level), 64'd0);

        // clr in the same cycle as a DUE accept: telemetry clears and the word is still stored.
        bus.in_valid   = 1'b1;
        bus.in_data    = 64'hDD;
        bus.in_err_loc = 4'hF;
        bus.in_due     = 1'b1;
        clr            = 1'b1;
        tick();
        clr            = 1'b0;
        bus.in_valid   = 1'b0;
        chk("clrdue_ce", 64'(ce_cnt), 64'd0);
        chk("clrdue_due", 64'(due_cnt), 64'd0);
        chk("clrdue_irq", 64'(irq_due), 64'd0);
        chk("clrdue_vld", 64'(last_err_vld), 64'd0);
        chk("clrdue_loc", 64'(last_err_loc), 64'hF);
        chk("clrdue_level", 64'(level), 64'd1);
        chk("clrdue_data", bus.out_data, 64'hDD);
        chk("clrdue_poison", 64'(bus.out_poison), 64'd1);

        // Asynchronous reset between clock edges.
        push_word(64'hEE, 4'hF, 1'b1);
        chk("arst_pre_level", 64'(level), 64'd2);
        chk("arst_pre_irq", 64'(irq_due), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_irq", 64'(irq_due), 64'd0);
        chk("arst_due", 64'(due_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_mis);
        $finish;
    end
endmodule

// File: doc/ip_daec_rd_resp_buffer.md
Name:
ip_daec_rd_resp_buffer

Overview:
- Sits directly downstream of ip_daec_decoder and consumes its per-codeword outputs: 64-bit data, 4-bit error location, 1-bit decode result.
- Buffers decoded read responses in a small first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Tags uncorrectable words as poisoned.
- Maintains saturating corrected-error (CE) and detected-uncorrectable-error (DUE) counters, a last-error log and a sticky DUE interrupt for the RAS/telemetry path.

Parameters:
DATA_W, 64, width of decoded data word
DEPTH, 4, FIFO entries (power of two, >= 2)
CNT_W, 16, width of CE/DUE counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoder output valid
in_ready  out  1  buffer can accept (= not full)
in_data  in  DATA_W  decoder data_out
in_err_loc  in  4  decoder error_location_out
in_due  in  1  decoder decode_result_out (1 = uncorrectable)
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_data  out  DATA_W  head data
out_poison  out  1  head entry is uncorrectable
level  out  $clog2(DEPTH)+1  current occupancy
ce_cnt  out  CNT_W  corrected-error count, saturating
due_cnt  out  CNT_W  uncorrectable count, saturating
last_err_loc  out  4  location of most recent error event
last_err_vld  out  1  last_err_loc holds a logged event
irq_due  out  1  sticky DUE interrupt
clr  in  1  synchronous clear of counters, log and irq

Behaviour:
- Clock and reset: one clock; rst_n is asynchronous assert, synchronous deassert, active-low.
- Reset values:
  - FIFO empty: out_valid=0, level=0, in_ready=1.
  - out_data=0, out_poison=0.
  - ce_cnt=0, due_cnt=0, last_err_loc=4'hF, last_err_vld=0, irq_due=0.
- Input classification, applied only on accept (in_valid & in_ready):
  - in_due=1 -> DUE, in_err_loc ignored.
  - in_due=0, in_err_loc=15 -> clean.
  - in_due=0, in_err_loc 0..9 -> CE on that 8-bit symbol (10 symbols per 80-bit codeword).
  - in_due=0, in_err_loc 10..14 -> illegal location, treated as DUE.
- FIFO:
  - Push on in_valid & in_ready; pop on out_valid & out_ready.
  - Stored entry is {data, poison}; poison = classification is DUE.
  - First-word-fall-through: a word pushed into an empty FIFO appears at out_valid/out_data the next cycle (latency 1). No same-cycle bypass.
  - in_ready = (level != DEPTH), combinational from state only, never from out_ready.
  - Full with simultaneous pop: in_ready stays 0 that cycle; no push.
  - Empty: pop impossible since out_valid=0.
  - Simultaneous push and pop when 0 < level < DEPTH: level unchanged.
  - Pointers wrap modulo DEPTH.
  - out_data/out_poison hold stable while out_valid & !out_ready.
- Counters, updated the cycle after accept:
  - CE increments ce_cnt; DUE increments due_cnt.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Log:
  - On CE: last_err_loc = in_err_loc, last_err_vld = 1.
  - On DUE: last_err_loc = 4'hE, last_err_vld = 1.
  - A later event always overwrites the log.
- irq_due is set on any DUE accept and held until clr.
- clr behaviour:
  - Zeroes ce_cnt and due_cnt, sets last_err_loc=4'hF, last_err_vld=0, irq_due=0.
  - clr has priority: an event accepted in the same cycle as clr is not counted, logged or irq-raised.
  - FIFO contents and poison are unaffected by clr.
- Reset mid-operation: all entries are discarded asynchronously. Counters, log and irq return to reset values.

Test Plan:
- Clean stream: push 4 words in_err_loc=15, in_due=0, data 64'h1..4, out_ready=0 -> level=4, in_ready=0. Raise out_ready -> words pop in order 1..4, out_poison=0, ce_cnt=0, due_cnt=0.
- CE logging: push in_err_loc=9, in_due=0 -> next cycle ce_cnt=1, last_err_loc=9, last_err_vld=1, irq_due=0. Then push in_err_loc=3 -> last_err_loc=3, ce_cnt=2.
- DUE and illegal location:
  - Push in_due=1 with in_err_loc=5 -> due_cnt=1, last_err_loc=4'hE, irq_due=1, popped entry has out_poison=1.
  - Then push in_err_loc=12, in_due=0 -> due_cnt=2, popped entry poisoned.
- Full boundary: fill to DEPTH, hold in_valid=1 and pulse out_ready=1 for one cycle -> exactly one pop, no push that cycle, level=3. Next cycle push is accepted and level=4.
- Saturation and clr:
  - Run with CNT_W=4 and 20 CE accepts -> ce_cnt=15.
  - Assert clr in the same cycle as a DUE accept -> ce_cnt=0, due_cnt=0, irq_due=0, last_err_vld=0, and the DUE word is still in the FIFO with out_poison=1.
- Async reset mid-operation: with level=2 and irq_due=1, pulse rst_n low between clock edges -> out_valid, level and irq_due drop to 0 immediately, without waiting for a clock edge.
